coco_tc_multi: RTL
==================

Name: coco_tc_multi

Overview:
Multi-channel, parametrised bus-mapped timer/counter peripheral for the MIPS-C SoC. It provides NCH independent down-counters of width CW behind one word-addressed register port. Each channel has a programmable prescaler and one of three modes: one-shot, auto-reload or PWM. Per-channel write-1-to-clear interrupt status and mask drive individual IRQ lines plus an OR'd interrupt output to the CP0 interrupt input.

Parameters:
NCH, 2, number of timer channels (1..4)
CW, 32, counter/preset width in bits (8..32)
PSW, 8, prescaler width in bits (1..16)

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
Add  in  4  word address: Add[3:2]=channel, Add[1:0]=register (0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS)
We  in  1  write enable, one write per cycle
Data_In  in  32  write data
Data_Out  out  32  combinational read of addressed register
Irq  out  NCH  per-channel interrupt, DONE & IM
Pwm  out  NCH  per-channel PWM output
Out  out  1  OR of all Irq bits

Behaviour:
- Register fields per channel:
  - CTRL[0] EN.
  - CTRL[2:1] MODE: 00 one-shot, 01 auto-reload, 10 PWM, 11 treated as one-shot.
  - CTRL[3] IM (interrupt mask).
  - CTRL[8+PSW-1:8] PRESCALE.
  - STATUS[0] DONE.
  - Unimplemented bits read 0.
- Reset (async, immediate, also mid-count): CTRL, PRESET, COUNT, STATUS and prescaler counters all 0. Irq, Pwm, Out and Data_Out are therefore 0.
- Writes (We=1, channel < NCH):
  - CTRL: loads the CTRL fields and clears that channel's prescaler counter.
  - PRESET: loads PRESET and COUNT from Data_In[CW-1:0], clears the prescaler.
  - COUNT: loads COUNT only.
  - STATUS: write-1-to-clear DONE.
  - Writes to channel >= NCH are ignored. Reads from channel >= NCH return 0.
  - Reads zero-extend CW to 32 bits. Writes truncate.
- Prescaler:
  - When EN=1, the prescaler counts 0..PRESCALE.
  - A tick occurs in the cycle the prescaler equals PRESCALE; the prescaler then returns to 0.
  - PRESCALE=0 gives a tick every cycle. A tick occurs every PRESCALE+1 cycles.
  - When EN=0, the prescaler holds and no ticks occur.
- On tick:
  - COUNT>1: decrement.
  - COUNT==1: COUNT<=0 and DONE<=1 on the same edge.
  - COUNT==0, one-shot: hold at 0, no further DONE.
  - COUNT==0, auto-reload/PWM: COUNT<=PRESET. If PRESET==0, COUNT stays 0 and DONE is not re-set.
  - Auto-reload period: PRESET+1 ticks from one 0 to the next.
- Pwm[i] = (MODE==10) & EN & (COUNT > PRESET>>1). Combinational from registers, 0 otherwise.
- Irq[i] = DONE & IM, combinational from registers. Out = |Irq.
- Collision priority:
  - A bus write to CTRL, PRESET or COUNT of a channel overrides that cycle's tick update to COUNT and the prescaler.
  - STATUS W1C in the same cycle as a DONE-set event leaves DONE=1, so no event is lost.
- Latency: a write is visible on Data_Out the next cycle. DONE and Irq are high in the first cycle COUNT reads 0.
- Channels are fully independent; there is no shared state except Out.

Test Plan:
- Reset: assert Reset mid-count (ch0 COUNT=5, EN=1) -> all regs read 0, Irq=0, Pwm=0, Out=0 immediately, before any clock edge.
- One-shot: ch0 PRESET=3, CTRL=0x9 (EN, one-shot, IM, PRESCALE=0) -> COUNT reads 3,2,1,0 on successive cycles. Irq[0]=Out=1 from the cycle COUNT=0. COUNT holds 0. Write STATUS=1 -> Irq[0]=0 next cycle.
- Auto-reload with prescaler: ch1 PRESET=2, CTRL=0x40B (EN, mode 01, IM, PRESCALE=4) -> COUNT changes every 5 cycles: 2,1,0,2,1,0. DONE set at each 0, so Irq[1] pulses of period 15 cycles when cleared each time.
- PWM: ch0 PRESET=9, CTRL=0x5 (EN, mode 10, PRESCALE=0) -> Pwm[0] high while COUNT in 9..5, low for 4..0. Period 10 cycles, 5 high.
- Collisions: W1C STATUS on the same edge COUNT goes 1->0 -> DONE=1 after the edge. Write COUNT=7 on a tick cycle -> COUNT reads 7, not the decremented value.
- Address/width (CW=16, NCH=2): write 0x12345678 to ch0 PRESET -> reads 0x00005678. Write to Add=4'b1101 (ch3) -> ignored, read returns 0.

Source files
------------

// File: rtl/coco_tc_multi_if.sv
// Register-port bundle for the coco_tc_multi timer/counter: word-addressed bus plus
// per-channel interrupt and PWM outputs.
interface coco_tc_multi_if #(
  parameter int unsigned NCH = 2
);
  logic [3:0]     Add;
  logic           We;
  logic [31:0]    Data_In;
  logic [31:0]    Data_Out;
  logic [NCH-1:0] Irq;
  logic [NCH-1:0] Pwm;
  logic           Out;

  modport master (
    output Add, We, Data_In,
    input  Data_Out, Irq, Pwm, Out
  );

  modport slave (
    input  Add, We, Data_In,
    output Data_Out, Irq, Pwm, Out
  );
endinterface

// File: rtl/coco_tc_multi.sv
// Multi-channel prescaled down-counter peripheral: one-shot, auto-reload and PWM modes,
// W1C done status with per-channel interrupt mask and an OR'd interrupt output.
module coco_tc_multi #(
  parameter int unsigned NCH = 2,
  parameter int unsigned CW  = 32,
  parameter int unsigned PSW = 8
) (
  input logic             Clk,
  input logic             Reset,
  coco_tc_multi_if.slave  bus
);

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_PRESET = 1;
  localparam int unsigned REG_COUNT  = 2;
  localparam int unsigned REG_STATUS = 3;

  logic [1:0] sel_ch;
  logic [1:0] sel_reg;
  logic [3:0][31:0] rd_word [NCH];

  assign sel_ch  = bus.Add[3:2];
  assign sel_reg = bus.Add[1:0];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic           en;
    logic [1:0]     mode;
    logic           im;
    logic [PSW-1:0] psc_lim;
    logic [PSW-1:0] psc;
    logic [CW-1:0]  preset;
    logic [CW-1:0]  count;
    logic           done;

    logic hit;
    logic wr_ctrl;
    logic wr_preset;
    logic wr_count;
    logic clr_done;
    logic tick;
    logic reload;
    logic set_done;

    assign hit       = bus.We && (sel_ch == 2'(i));
    assign wr_ctrl   = hit && (sel_reg == 2'(REG_CTRL));
    assign wr_preset = hit && (sel_reg == 2'(REG_PRESET));
    assign wr_count  = hit && (sel_reg == 2'(REG_COUNT));
    assign clr_done  = hit && (sel_reg == 2'(REG_STATUS)) && bus.Data_In[0];

    assign tick     = en && (psc == psc_lim);
    assign reload   = (mode == 2'b01) || (mode == 2'b10);
    // A register write in the same cycle wins over the tick, including its DONE event.
    assign set_done = tick && !(wr_ctrl || wr_preset || wr_count) && (count == CW'(1));

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        en      <= 1'b0;
        mode    <= 2'b00;
        im      <= 1'b0;
        psc_lim <= '0;
        psc     <= '0;
        preset  <= '0;
        count   <= '0;
        done    <= 1'b0;
      end else begin
        if (wr_ctrl) begin
          en      <= bus.Data_In[0];
          mode    <= bus.Data_In[2:1];
          im      <= bus.Data_In[3];
          psc_lim <= bus.Data_In[8+PSW-1:8];
        end

        if (wr_ctrl || wr_preset) begin
          psc <= '0;
        end else if (!wr_count && en) begin
          psc <= tick ? '0 : psc + PSW'(1);
        end

        if (wr_preset) begin
          preset <= bus.Data_In[CW-1:0];
          count  <= bus.Data_In[CW-1:0];
        end else if (wr_count) begin
          count <= bus.Data_In[CW-1:0];
        end else if (!wr_ctrl && tick) begin
          if (count != '0) begin
            count <= count - CW'(1);
          end else if (reload) begin
            count <= preset;
          end
        end

        done <= set_done || (done && !clr_done);
      end
    end

    assign bus.Irq[i] = done && im;
    assign bus.Pwm[i] = (mode == 2'b10) && en && (count > (preset >> 1));

    assign rd_word[i][REG_CTRL]   = (32'(psc_lim) << 8) | 32'({im, mode, en});
    assign rd_word[i][REG_PRESET] = 32'(preset);
    assign rd_word[i][REG_COUNT]  = 32'(count);
    assign rd_word[i][REG_STATUS] = 32'(done);
  end

  // Read mux; channels at or above NCH read as zero.
  always_comb begin
    bus.Data_Out = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_ch == 2'(i)) begin
        bus.Data_Out = rd_word[i][sel_reg];
      end
    end
  end

  assign bus.Out = |bus.Irq;

endmodule
